// File: rtl/scarf_regmap_gen_if.sv
// SCARF byte-stream bus between the protocol front end and a register map.
// The master drives the received byte stream and transfer framing, and the
// slave (the register map) returns the read byte.
interface scarf_regmap_gen_if;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_finished;
    logic [6:0] slave_id;
    logic       rnw;
    logic [7:0] read_data_out;

    modport master (
        output data_in, data_in_valid, data_in_finished, slave_id, rnw,
        input  read_data_out
    );

    modport slave (
        input  data_in, data_in_valid, data_in_finished, slave_id, rnw,
        output read_data_out
    );
endinterface

// File: rtl/scarf_regmap_gen.sv
// SCARF register map: NUM_RW read/write control registers followed by
// NUM_RO status registers, addressed by an auto-incrementing byte pointer.
// The first byte of a selected transfer is the start address; every later
// byte is a data byte at the current pointer.
// Build option SCARF_REGMAP_STICKY_EN: status bits become sticky and are
// cleared by writing 1 (set wins over a coincident clear). Without it the
// status registers are a one-cycle-delayed copy of status_in and ignore writes.
module scarf_regmap_gen #(
    parameter logic [6:0]          SLAVE_ID = 7'h01,
    parameter int                  NUM_RW   = 4,
    parameter int                  NUM_RO   = 2,
    parameter logic [NUM_RW*8-1:0] RST_VAL  = '0,
    parameter bit                  WRAP     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n_sync,
    scarf_regmap_gen_if.slave     bus,
    input  logic [NUM_RO*8-1:0]   status_in,
    output logic [NUM_RW*8-1:0]   regs_out,
    output logic [NUM_RW-1:0]     wr_strobe,
    output logic                  addr_err
);
    localparam int NUM_REGS = NUM_RW + NUM_RO;
    localparam int TOP      = NUM_REGS - 1;

    logic [7:0]          ptr;
    logic                first_q;
    logic                final_q;
    logic [NUM_RW*8-1:0] rw_q;
    logic [NUM_RO*8-1:0] ro_q;
    logic [7:0]          rd_data;

    logic sel;
    logic load;
    logic acc;
    logic wr_acc;
    logic in_range;
    logic ptr_top;

    assign sel      = (bus.slave_id == SLAVE_ID);
    assign load     = sel && bus.data_in_valid && !bus.data_in_finished && first_q;
    assign acc      = sel && bus.data_in_valid && !bus.data_in_finished && !first_q && !final_q;
    assign wr_acc   = acc && !bus.rnw;
    assign in_range = (int'(ptr) < NUM_REGS);
    assign ptr_top  = (int'(ptr) == TOP);

    // Address pointer and transfer framing; end of transfer wins over a data byte.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            ptr     <= 8'h00;
            first_q <= 1'b1;
            final_q <= 1'b0;
        end else if (bus.data_in_finished) begin
            ptr     <= 8'h00;
            first_q <= 1'b1;
            final_q <= 1'b0;
        end else if (load) begin
            ptr     <= bus.data_in;
            first_q <= 1'b0;
        end else if (acc) begin
            if (ptr_top) begin
                if (WRAP) ptr     <= 8'h00;
                else      final_q <= 1'b1;
            end else begin
                ptr <= ptr + 8'd1;
            end
        end
    end

    // Control registers and their one-cycle write strobes.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            rw_q      <= RST_VAL;
            wr_strobe <= '0;
        end else begin
            wr_strobe <= '0;
            for (int k = 0; k < NUM_RW; k++) begin
                if (wr_acc && int'(ptr) == k) begin
                    rw_q[k*8 +: 8] <= bus.data_in;
                    wr_strobe[k]   <= 1'b1;
                end
            end
        end
    end

`ifdef SCARF_REGMAP_STICKY_EN
    logic [NUM_RO*8-1:0] ro_clr;

    // Write-1-to-clear mask for the status register at the pointer.
    always_comb begin
        ro_clr = '0;
        for (int j = 0; j < NUM_RO; j++) begin
            if (wr_acc && int'(ptr) == NUM_RW + j) ro_clr[j*8 +: 8] = bus.data_in;
        end
    end

    // Sticky status bits; a live status bit overrides a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) ro_q <= '0;
        else             ro_q <= (ro_q & ~ro_clr) | status_in;
    end
`else
    // Status registers track status_in with one cycle of latency.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) ro_q <= '0;
        else             ro_q <= status_in;
    end
`endif

    // Sticky flag for any data byte aimed past the last register.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync)            addr_err <= 1'b0;
        else if (acc && !in_range)  addr_err <= 1'b1;
    end

    // Read return: slave ID while the address byte is pending, then the register.
    always_comb begin
        rd_data = 8'h00;
        if (sel && bus.rnw) begin
            if (first_q) begin
                rd_data = {1'b0, SLAVE_ID};
            end else if (!final_q) begin
                for (int k = 0; k < NUM_RW; k++) begin
                    if (int'(ptr) == k) rd_data = rw_q[k*8 +: 8];
                end
                for (int j = 0; j < NUM_RO; j++) begin
                    if (int'(ptr) == NUM_RW + j) rd_data = ro_q[j*8 +: 8];
                end
            end
        end
    end

    assign bus.read_data_out = rd_data;
    assign regs_out          = rw_q;
endmodule

// File: tb/tb_scarf_regmap_gen.sv
// Bench for scarf_regmap_gen: two instances (WRAP=0 and WRAP=1) share one
// stimulus stream; expected read bytes go through a scoreboard queue.
module tb_scarf_regmap_gen;
    localparam logic [31:0] RV = 32'h4433_2211;

    logic        clk = 1'b0;
    logic        rst_n_sync;
    logic [15:0] status_in;
    logic [31:0] regs0, regs1;
    logic [3:0]  stb0, stb1;
    logic        err0, err1;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q0[$];
    logic [7:0]  exp_q1[$];

    always #5 clk = ~clk;

    scarf_regmap_gen_if bus0();
    scarf_regmap_gen_if bus1();

    assign bus1.data_in          = bus0.data_in;
    assign bus1.data_in_valid    = bus0.data_in_valid;
    assign bus1.data_in_finished = bus0.data_in_finished;
    assign bus1.slave_id         = bus0.slave_id;
    assign bus1.rnw              = bus0.rnw;

    scarf_regmap_gen #(.SLAVE_ID(7'h01), .NUM_RW(4), .NUM_RO(2), .RST_VAL(RV), .WRAP(1'b0)) dut0 (
        .clk(clk), .rst_n_sync(rst_n_sync), .bus(bus0), .status_in(status_in),
        .regs_out(regs0), .wr_strobe(stb0), .addr_err(err0)
    );

    scarf_regmap_gen #(.SLAVE_ID(7'h01), .NUM_RW(4), .NUM_RO(2), .RST_VAL(RV), .WRAP(1'b1)) dut1 (
        .clk(clk), .rst_n_sync(rst_n_sync), .bus(bus1), .status_in(status_in),
        .regs_out(regs1), .wr_strobe(stb1), .addr_err(err1)
    );

    // One data byte: expected read bytes queued, read_data_out compared while valid is high.
    task automatic send(input logic [7:0] b, input logic [7:0] e0, input logic [7:0] e1);
        logic [7:0] a0, a1, x0, x1;
        exp_q0.push_back(e0);
        exp_q1.push_back(e1);
        @(negedge clk);
        bus0.data_in       = b;
        bus0.data_in_valid = 1'b1;
        #1;
        a0 = bus0.read_data_out;
        a1 = bus1.read_data_out;
        x0 = exp_q0.pop_front();
        x1 = exp_q1.pop_front();
        checks++;
        if (a0 !== x0) begin
            errors++;
            $display("FAIL rd_wrap0 byte=%h: got %h expected %h", b, a0, x0);
        end
        checks++;
        if (a1 !== x1) begin
            errors++;
            $display("FAIL rd_wrap1 byte=%h: got %h expected %h", b, a1, x1);
        end
        @(negedge clk);
        bus0.data_in_valid = 1'b0;
    endtask

    task automatic finish_xfer();
        @(negedge clk);
        bus0.data_in_finished = 1'b1;
        @(negedge clk);
        bus0.data_in_finished = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_sync            = 1'b0;
        bus0.slave_id         = 7'h7F;
        bus0.rnw              = 1'b1;
        bus0.data_in          = 8'h00;
        bus0.data_in_valid    = 1'b0;
        bus0.data_in_finished = 1'b0;
        status_in             = 16'hC35A;
        repeat (3) @(negedge clk);
        checks++;
        if (regs0 !== RV || regs1 !== RV) begin
            errors++;
            $display("FAIL reset_regs: got %h/%h expected %h", regs0, regs1, RV);
        end
        checks++;
        if (stb0 !== 4'b0 || stb1 !== 4'b0 || err0 !== 1'b0 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got stb %b/%b err %b/%b expected 0", stb0, stb1, err0, err1);
        end
        checks++;
        if (bus0.read_data_out !== 8'h00 || bus1.read_data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd: got %h/%h expected 00", bus0.read_data_out, bus1.read_data_out);
        end
        rst_n_sync = 1'b1;
        @(negedge clk);
        bus0.slave_id = 7'h01;
        #1;
        checks++;
        if (bus0.read_data_out !== 8'h01 || bus1.read_data_out !== 8'h01) begin
            errors++;
            $display("FAIL reset_id: got %h/%h expected 01", bus0.read_data_out, bus1.read_data_out);
        end
    endtask

    task automatic test_write();
        bus0.slave_id = 7'h01;
        bus0.rnw      = 1'b0;
        send(8'h00, 8'h00, 8'h00);
        checks++;
        if (stb0 !== 4'b0000) begin
            errors++;
            $display("FAIL wr_addr_strobe: got %b expected 0000", stb0);
        end
        send(8'hA5, 8'h00, 8'h00);
        checks++;
        if (stb0 !== 4'b0001 || stb1 !== 4'b0001 || regs0[7:0] !== 8'hA5) begin
            errors++;
            $display("FAIL wr_a5: got stb %b/%b reg0 %h expected 0001 A5", stb0, stb1, regs0[7:0]);
        end
        send(8'h3C, 8'h00, 8'h00);
        checks++;
        if (stb0 !== 4'b0010 || stb1 !== 4'b0010) begin
            errors++;
            $display("FAIL wr_3c_strobe: got %b/%b expected 0010", stb0, stb1);
        end
        @(negedge clk);
        checks++;
        if (stb0 !== 4'b0000 || stb1 !== 4'b0000) begin
            errors++;
            $display("FAIL wr_strobe_width: got %b/%b expected 0000", stb0, stb1);
        end
        finish_xfer();
        checks++;
        if (regs0 !== 32'h4433_3CA5 || regs1 !== 32'h4433_3CA5) begin
            errors++;
            $display("FAIL wr_regs: got %h/%h expected 44333ca5", regs0, regs1);
        end
    endtask

    task automatic test_read();
        bus0.slave_id = 7'h01;
        bus0.rnw      = 1'b1;
        send(8'h02, 8'h01, 8'h01);
        send(8'h00, 8'h33, 8'h33);
        send(8'h00, 8'h44, 8'h44);
        send(8'h00, 8'h5A, 8'h5A);
        send(8'h00, 8'hC3, 8'hC3);
        send(8'h00, 8'h00, 8'hA5);
        finish_xfer();
        bus0.slave_id = 7'h05;
        send(8'h02, 8'h00, 8'h00);
        send(8'h00, 8'h00, 8'h00);
        finish_xfer();
        checks++;
        if (err0 !== 1'b0 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL rd_no_err: got %b/%b expected 0", err0, err1);
        end
        bus0.slave_id = 7'h01;
    endtask

    task automatic test_wrap();
        bus0.rnw = 1'b0;
        send(8'h05, 8'h00, 8'h00);
        send(8'h11, 8'h00, 8'h00);
        checks++;
        if (stb0 !== 4'b0000 || stb1 !== 4'b0000) begin
            errors++;
            $display("FAIL wrap_status_strobe: got %b/%b expected 0000", stb0, stb1);
        end
        send(8'h22, 8'h00, 8'h00);
        checks++;
        if (stb0 !== 4'b0000 || regs0 !== 32'h4433_3CA5) begin
            errors++;
            $display("FAIL wrap0_final: got stb %b regs %h expected 0000 44333ca5", stb0, regs0);
        end
        checks++;
        if (stb1 !== 4'b0001 || regs1 !== 32'h4433_3C22) begin
            errors++;
            $display("FAIL wrap1_reg0: got stb %b regs %h expected 0001 44333c22", stb1, regs1);
        end
        finish_xfer();
    endtask

    task automatic test_addr_err();
        bus0.rnw = 1'b1;
        send(8'hFF, 8'h01, 8'h01);
        checks++;
        if (err0 !== 1'b0 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL err_early: got %b/%b expected 0", err0, err1);
        end
        send(8'h00, 8'h00, 8'h00);
        checks++;
        if (err0 !== 1'b1 || err1 !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got %b/%b expected 1", err0, err1);
        end
        finish_xfer();
        bus0.rnw = 1'b0;
        send(8'h00, 8'h00, 8'h00);
        send(8'hA5, 8'h00, 8'h00);
        finish_xfer();
        checks++;
        if (err0 !== 1'b1 || err1 !== 1'b1 || regs1 !== 32'h4433_3CA5) begin
            errors++;
            $display("FAIL err_held: got err %b/%b regs1 %h expected 1 44333ca5", err0, err1, regs1);
        end
    endtask

    task automatic test_finish_priority();
        bus0.rnw = 1'b0;
        send(8'h00, 8'h00, 8'h00);
        @(negedge clk);
        bus0.data_in          = 8'h5E;
        bus0.data_in_valid    = 1'b1;
        bus0.data_in_finished = 1'b1;
        @(negedge clk);
        bus0.data_in_valid    = 1'b0;
        bus0.data_in_finished = 1'b0;
        send(8'h02, 8'h00, 8'h00);
        send(8'h6B, 8'h00, 8'h00);
        checks++;
        if (stb0 !== 4'b0100 || regs0 !== 32'h446B_3CA5 || regs1 !== 32'h446B_3CA5) begin
            errors++;
            $display("FAIL finish_prio: got stb %b regs %h/%h expected 0100 446b3ca5", stb0, regs0, regs1);
        end
        finish_xfer();
    endtask

`ifdef SCARF_REGMAP_STICKY_EN
    task automatic test_status();
        status_in = 16'hC300;
        repeat (2) @(negedge clk);
        bus0.rnw = 1'b0;
        send(8'h04, 8'h00, 8'h00);
        send(8'hFF, 8'h00, 8'h00);
        finish_xfer();
        bus0.rnw = 1'b1;
        send(8'h04, 8'h01, 8'h01);
        send(8'h00, 8'h00, 8'h00);
        finish_xfer();
        @(negedge clk);
        status_in = 16'hC301;
        @(negedge clk);
        status_in = 16'hC300;
        send(8'h04, 8'h01, 8'h01);
        send(8'h00, 8'h01, 8'h01);
        finish_xfer();
        bus0.rnw = 1'b0;
        send(8'h04, 8'h00, 8'h00);
        send(8'h01, 8'h00, 8'h00);
        finish_xfer();
        bus0.rnw = 1'b1;
        send(8'h04, 8'h01, 8'h01);
        send(8'h00, 8'h00, 8'h00);
        finish_xfer();
        status_in = 16'hC301;
        bus0.rnw = 1'b0;
        send(8'h04, 8'h00, 8'h00);
        send(8'h01, 8'h00, 8'h00);
        finish_xfer();
        bus0.rnw = 1'b1;
        send(8'h04, 8'h01, 8'h01);
        send(8'h00, 8'h01, 8'h01);
        finish_xfer();
    endtask
`else
    task automatic test_status();
        status_in = 16'hC3A7;
        repeat (2) @(negedge clk);
        bus0.rnw = 1'b1;
        send(8'h04, 8'h01, 8'h01);
        send(8'h00, 8'hA7, 8'hA7);
        finish_xfer();
        bus0.rnw = 1'b0;
        send(8'h04, 8'h00, 8'h00);
        send(8'hFF, 8'h00, 8'h00);
        finish_xfer();
        bus0.rnw = 1'b1;
        send(8'h04, 8'h01, 8'h01);
        send(8'h00, 8'hA7, 8'hA7);
        finish_xfer();
    endtask
`endif

    task automatic test_reset_mid();
        bus0.rnw = 1'b0;
        send(8'h01, 8'h00, 8'h00);
        send(8'h77, 8'h00, 8'h00);
        checks++;
        if (regs0[15:8] !== 8'h77 || regs1[15:8] !== 8'h77) begin
            errors++;
            $display("FAIL mid_pre: got %h/%h expected 77", regs0[15:8], regs1[15:8]);
        end
        @(negedge clk);
        rst_n_sync = 1'b0;
        #1;
        checks++;
        if (regs0 !== RV || regs1 !== RV || err0 !== 1'b0 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got regs %h/%h err %b/%b expected %h 0", regs0, regs1, err0, err1, RV);
        end
        @(negedge clk);
        rst_n_sync = 1'b1;
        send(8'h03, 8'h00, 8'h00);
        send(8'h99, 8'h00, 8'h00);
        checks++;
        if (stb0 !== 4'b1000 || regs0 !== 32'h9933_2211 || regs1 !== 32'h9933_2211) begin
            errors++;
            $display("FAIL mid_readdr: got stb %b regs %h/%h expected 1000 99332211", stb0, regs0, regs1);
        end
        finish_xfer();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_addr_err();
        test_finish_priority();
        test_status();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
